// File: rtl/boruss_cpu_pkg.sv
// Shared definitions for the Boruss CPU control path: state codes, opcodes,
// flag bit positions and the width-dependent HALT/RETI instruction encodings.
package boruss_cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4,
        ST_IRQ       = 3'd5,
        ST_RSVD6     = 3'd6,
        ST_RSVD7     = 3'd7
    } state_t;

    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JNZ = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_JNC = 4'hC;
    localparam logic [3:0] OP_JN  = 4'hD;
    localparam logic [3:0] OP_JP  = 4'hE;
    localparam logic [3:0] OP_CMP = 4'hF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    typedef logic [2:0] flags_t;

    // All-ones instruction word of width w (w <= 32).
    function automatic logic [31:0] halt_code(input int w);
        if (w >= 32)
            return '1;
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] reti_code(input int w);
        return halt_code(w) - 32'd1;
    endfunction

endpackage

// File: rtl/boruss_branch_unit.sv
// Conditional-jump resolver: decides from the opcode and the stored Z/C/N
// flags whether a jump instruction is taken. Non-jump opcodes never take.
module boruss_branch_unit
    import boruss_cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  flags_t     flags,
    output logic       take_jump
);

    always_comb begin
        take_jump = 1'b0;
        case (opcode)
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = flags[FLAG_Z];
            OP_JNZ:  take_jump = ~flags[FLAG_Z];
            OP_JC:   take_jump = flags[FLAG_C];
            OP_JNC:  take_jump = ~flags[FLAG_C];
            OP_JN:   take_jump = flags[FLAG_N];
            OP_JP:   take_jump = ~flags[FLAG_N];
            default: take_jump = 1'b0;
        endcase
    end

endmodule

// File: rtl/boruss_cpu_ctrl_fsm.sv
// Boruss CPU control FSM: fetch/decode/execute/writeback sequencing with
// wait-state fetch, ALU stall, one maskable interrupt, RETI and HALT wake-up.
module boruss_cpu_ctrl_fsm
    import boruss_cpu_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'('h80)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              alu_busy,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_neg,
    input  logic              irq,
    input  logic              irq_en_set,
    output logic [2:0]        state,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic [3:0]        opcode,
    output logic [1:0]        dest_reg,
    output logic [1:0]        src_reg,
    output logic              update_regs,
    output logic              update_flags,
    output logic              jump_taken,
    output logic              irq_ack,
    output logic              halted
);

    localparam logic [31:0]       HALT32     = halt_code(DATA_W);
    localparam logic [31:0]       RETI32     = reti_code(DATA_W);
    localparam logic [DATA_W-1:0] HALT_INSTR = HALT32[DATA_W-1:0];
    localparam logic [DATA_W-1:0] RETI_INSTR = RETI32[DATA_W-1:0];

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] epc_reg;
    logic [DATA_W-1:0] instr_reg;
    flags_t            flags_reg;
    flags_t            saved_flags_reg;
    logic              ie_reg;

    logic              is_halt;
    logic              is_reti;
    logic              is_alu_op;
    logic              is_cmp;
    logic              take_jump;
    logic              irq_pending;
    logic [ADDR_W-1:0] pc_inc;
    flags_t            alu_flags;

    assign opcode      = instr_reg[DATA_W-1 -: 4];
    assign dest_reg    = instr_reg[3:2];
    assign src_reg     = instr_reg[1:0];
    assign instr       = instr_reg;
    assign pc          = pc_reg;
    assign imem_addr   = pc_reg;
    assign state       = state_reg;
    assign halted      = (state_reg == ST_HALT);

    assign is_halt     = (instr_reg == HALT_INSTR);
    assign is_reti     = (instr_reg == RETI_INSTR);
    assign is_alu_op   = ~opcode[3];
    assign is_cmp      = (opcode == OP_CMP);
    assign irq_pending = irq & ie_reg;
    assign pc_inc      = pc_reg + ADDR_W'(1);

    assign alu_flags[FLAG_Z] = alu_zero;
    assign alu_flags[FLAG_C] = alu_carry;
    assign alu_flags[FLAG_N] = alu_neg;

    // Gated by reset so the request drops the moment reset asserts, not at the next edge.
    assign imem_req = (state_reg == ST_FETCH) & reset;

    boruss_branch_unit u_branch (
        .opcode    (opcode),
        .flags     (flags_reg),
        .take_jump (take_jump)
    );

    always_comb begin
        state_next   = state_reg;
        update_regs  = 1'b0;
        update_flags = 1'b0;
        jump_taken   = 1'b0;
        irq_ack      = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                if (imem_ack)
                    state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_halt)
                    state_next = ST_HALT;
                else if (is_reti)
                    state_next = ST_WRITEBACK;
                else
                    state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (!alu_busy)
                    state_next = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                if (!is_reti) begin
                    if (is_alu_op) begin
                        update_regs  = 1'b1;
                        update_flags = 1'b1;
                    end else if (is_cmp) begin
                        update_flags = 1'b1;
                    end else begin
                        jump_taken = take_jump;
                    end
                end
                state_next = irq_pending ? ST_IRQ : ST_FETCH;
            end
            ST_HALT: begin
                if (irq_pending)
                    state_next = ST_IRQ;
            end
            ST_IRQ: begin
                irq_ack    = 1'b1;
                state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_FETCH;
            pc_reg          <= RESET_VECTOR;
            epc_reg         <= '0;
            instr_reg       <= '0;
            flags_reg       <= '0;
            saved_flags_reg <= '0;
            ie_reg          <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (irq_en_set)
                ie_reg <= 1'b1;
            case (state_reg)
                ST_FETCH: begin
                    if (imem_ack)
                        instr_reg <= imem_rdata;
                end
                ST_WRITEBACK: begin
                    if (is_reti) begin
                        pc_reg    <= epc_reg;
                        flags_reg <= saved_flags_reg;
                        ie_reg    <= 1'b1;
                    end else begin
                        pc_reg <= jump_taken ? alu_result : pc_inc;
                        if (update_flags)
                            flags_reg <= alu_flags;
                    end
                end
                ST_HALT: begin
                    // Advancing here makes the IRQ state save the address after HALT.
                    if (irq_pending)
                        pc_reg <= pc_inc;
                end
                ST_IRQ: begin
                    epc_reg         <= pc_reg;
                    saved_flags_reg <= flags_reg;
                    pc_reg          <= IRQ_VECTOR;
                    ie_reg          <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boruss_cpu_ctrl_fsm.sv
// Scoreboard bench for boruss_cpu_ctrl_fsm: an 8-bit core runs a directed
// program against a memory/ALU model, a 16/12-bit core checks PC wrap.
module tb_boruss_cpu_ctrl_fsm;

    typedef struct {
        int          kind;   // 0 writeback, 1 irq entry, 2 halt entry
        logic        wr;
        logic        fl;
        logic        jp;
        logic [11:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rst16 = 1'b0;
    always #5 clk = ~clk;

    // 8-bit core
    logic        imem_req, imem_ack, alu_busy, alu_zero, alu_carry, alu_neg;
    logic        irq, irq_en_set, update_regs, update_flags, jump_taken, irq_ack, halted;
    logic [7:0]  imem_addr, imem_rdata, alu_result, pc, instr;
    logic [2:0]  state;
    logic [3:0]  opcode;
    logic [1:0]  dest_reg, src_reg;

    // 16/12-bit core
    logic        imem_req16, imem_ack16, update_regs16, update_flags16, jump_taken16, irq_ack16, halted16;
    logic [11:0] imem_addr16, pc16;
    logic [15:0] imem_rdata16, instr16;
    logic [2:0]  state16;
    logic [3:0]  opcode16;
    logic [1:0]  dest_reg16, src_reg16;

    boruss_cpu_ctrl_fsm #(.DATA_W(8), .ADDR_W(8), .RESET_VECTOR(8'h00), .IRQ_VECTOR(8'h80)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .alu_busy(alu_busy), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_neg(alu_neg), .irq(irq), .irq_en_set(irq_en_set), .state(state),
        .pc(pc), .instr(instr), .opcode(opcode), .dest_reg(dest_reg), .src_reg(src_reg),
        .update_regs(update_regs), .update_flags(update_flags), .jump_taken(jump_taken),
        .irq_ack(irq_ack), .halted(halted)
    );

    boruss_cpu_ctrl_fsm #(.DATA_W(16), .ADDR_W(12), .RESET_VECTOR(12'hFFF), .IRQ_VECTOR(12'h080)) dut16 (
        .clk(clk), .reset(rst16), .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_ack(imem_ack16),
        .imem_rdata(imem_rdata16), .alu_busy(1'b0), .alu_result(12'h000), .alu_zero(1'b0),
        .alu_carry(1'b0), .alu_neg(1'b0), .irq(1'b0), .irq_en_set(1'b0), .state(state16),
        .pc(pc16), .instr(instr16), .opcode(opcode16), .dest_reg(dest_reg16), .src_reg(src_reg16),
        .update_regs(update_regs16), .update_flags(update_flags16), .jump_taken(jump_taken16),
        .irq_ack(irq_ack16), .halted(halted16)
    );

    logic [7:0] mem      [256];
    int         wait_tab [256];
    int         busy_tab [256];
    logic [7:0] res_tab  [256];
    logic [2:0] flg_tab  [256];   // {N, C, Z} driven during that instruction

    exp_t sb[$];
    exp_t sb16[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   irq_mode = 0;           // 0 off, 1 fire during EXECUTE at 0x10, 2 hold until acked
    int   exe_len_10 = 0;
    logic exe_strobe_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic wr, input logic fl, input logic jp, input logic [11:0] p);
        exp_t e;
        e.kind = k; e.wr = wr; e.fl = fl; e.jp = jp; e.pc = p;
        sb.push_back(e);
        $display("expect  kind=%0d regs=%0b flags=%0b jump=%0b pc=0x%03h", k, wr, fl, jp, p);
    endtask

    // Memory and ALU model for the 8-bit core.
    initial begin
        int wcnt;
        int busy_cnt;
        logic acked;
        wcnt = 0; busy_cnt = 0; acked = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; alu_busy = 1'b0; alu_result = '0;
        alu_zero = 1'b0; alu_carry = 1'b0; alu_neg = 1'b0; irq = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (imem_req) begin
                if (wcnt >= wait_tab[imem_addr]) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                    wcnt       = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            alu_result = res_tab[pc];
            {alu_neg, alu_carry, alu_zero} = flg_tab[pc];
            if (state == 3'd1) begin
                busy_cnt = busy_tab[pc];
                alu_busy = 1'b1;
            end else if (state == 3'd2) begin
                alu_busy = (busy_cnt != 0);
                if (busy_cnt != 0) busy_cnt--;
            end else begin
                alu_busy = 1'b1;
            end
            if (state == 3'd5) begin
                irq = 1'b0;
                acked = 1'b1;
            end else if (irq_mode == 0) begin
                irq = 1'b0;
                acked = 1'b0;
            end else if (!acked && (irq_mode == 2 || (state == 3'd2 && pc == 8'h10))) begin
                irq = 1'b1;
            end
        end
    end

    // Zero-wait memory for the wide core: ALU op at 0xFFF, HALT everywhere else.
    initial begin
        imem_ack16 = 1'b0; imem_rdata16 = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack16   = imem_req16;
            imem_rdata16 = (imem_addr16 == 12'hFFF) ? 16'h1234 : 16'hFFFF;
        end
    end

    // EXECUTE run-length probe for the stalled instruction at 0x10.
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (state == 3'd2) begin
                run++;
                if (pc == 8'h10 && (update_regs || update_flags || jump_taken)) exe_strobe_seen = 1'b1;
            end else begin
                if (run != 0 && pc == 8'h10) exe_len_10 = run;
                run = 0;
            end
        end
    end

    // Monitor for the 8-bit core.
    initial begin
        exp_t cur;
        logic pend, halted_d;
        pend = 1'b0; halted_d = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("pc_after", {24'h0, pc}, {20'h0, cur.pc});
                pend = 1'b0;
            end
            if (reset && (state == 3'd3 || state == 3'd5 || (halted && !halted_d))) begin
                $display("observe state=%0d pc=0x%02h regs=%0b flags=%0b jump=%0b ack=%0b",
                         state, pc, update_regs, update_flags, jump_taken, irq_ack);
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_event: got state %0d, expected no event", state);
                end else begin
                    cur = sb.pop_front();
                    check("state", {29'h0, state}, (cur.kind == 0) ? 32'd3 : ((cur.kind == 1) ? 32'd5 : 32'd4));
                    check("update_regs", {31'h0, update_regs}, {31'h0, cur.wr});
                    check("update_flags", {31'h0, update_flags}, {31'h0, cur.fl});
                    check("jump_taken", {31'h0, jump_taken}, {31'h0, cur.jp});
                    check("irq_ack", {31'h0, irq_ack}, (cur.kind == 1) ? 32'd1 : 32'd0);
                    if (cur.kind == 2) check("halt_pc", {24'h0, pc}, {20'h0, cur.pc});
                    else pend = 1'b1;
                end
            end
            halted_d = halted;
        end
    end

    // Monitor for the wide core.
    initial begin
        exp_t cur;
        logic pend, halted_d;
        pend = 1'b0; halted_d = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("w_pc_after", {20'h0, pc16}, {20'h0, cur.pc});
                pend = 1'b0;
            end
            if (rst16 && (state16 == 3'd3 || (halted16 && !halted_d))) begin
                $display("observe16 state=%0d pc=0x%03h regs=%0b flags=%0b", state16, pc16, update_regs16, update_flags16);
                if (sb16.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL w_unexpected_event: got state %0d, expected no event", state16);
                end else begin
                    cur = sb16.pop_front();
                    check("w_state", {29'h0, state16}, (cur.kind == 0) ? 32'd3 : 32'd4);
                    check("w_update_regs", {31'h0, update_regs16}, {31'h0, cur.wr});
                    check("w_update_flags", {31'h0, update_flags16}, {31'h0, cur.fl});
                    if (cur.kind == 2) check("w_halt_pc", {20'h0, pc16}, {20'h0, cur.pc});
                    else pend = 1'b1;
                end
            end
            halted_d = halted16;
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got no completion, expected finish within 20000 cycles");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int req_cycles;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00; wait_tab[i] = 0; busy_tab[i] = 0; res_tab[i] = 8'h00; flg_tab[i] = 3'b000;
        end
        mem[8'h00] = 8'h15; wait_tab[8'h00] = 3; flg_tab[8'h00] = 3'b001;
        mem[8'h01] = 8'h90; res_tab[8'h01] = 8'h40;
        mem[8'h40] = 8'h90; res_tab[8'h40] = 8'h10;
        mem[8'h10] = 8'h26; busy_tab[8'h10] = 5; flg_tab[8'h10] = 3'b010; wait_tab[8'h10] = 1;
        mem[8'h80] = 8'h94; res_tab[8'h80] = 8'h33; flg_tab[8'h80] = 3'b111; wait_tab[8'h80] = 2;
        mem[8'h81] = 8'h3B; flg_tab[8'h81] = 3'b101;
        mem[8'h82] = 8'hF1; flg_tab[8'h82] = 3'b101;
        mem[8'h83] = 8'hFE;
        mem[8'h11] = 8'hB0; res_tab[8'h11] = 8'h20;
        mem[8'h20] = 8'hA0; res_tab[8'h20] = 8'h30;
        mem[8'h30] = 8'hFF;

        push(0, 1, 1, 0, 12'h001);   // ALU op 0x15, Z:=1
        push(0, 0, 0, 1, 12'h040);   // JZ taken
        push(0, 0, 0, 1, 12'h010);   // JZ again: jump left Z intact
        push(0, 1, 1, 0, 12'h011);   // stalled ALU op, Z=0 C=1
        push(1, 0, 0, 0, 12'h080);   // interrupt entry
        push(0, 0, 0, 0, 12'h081);   // JZ not taken (Z=0)
        push(0, 1, 1, 0, 12'h082);   // ALU op clobbers flags Z=1 N=1 C=0
        push(0, 0, 1, 0, 12'h083);   // CMP: flags only
        push(0, 0, 0, 0, 12'h011);   // RETI to epc
        push(0, 0, 0, 1, 12'h020);   // JC taken: C restored
        push(0, 0, 0, 1, 12'h030);   // JNZ taken: Z restored
        push(2, 0, 0, 0, 12'h030);   // HALT
        sb16.push_back('{kind: 0, wr: 1'b1, fl: 1'b1, jp: 1'b0, pc: 12'h000});
        sb16.push_back('{kind: 2, wr: 1'b0, fl: 1'b0, jp: 1'b0, pc: 12'h000});

        irq_en_set = 1'b0;
        irq_mode   = 1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_state", {29'h0, state}, 32'd0);
        check("rst_pc", {24'h0, pc}, 32'h00);
        check("rst_instr", {24'h0, instr}, 32'h00);
        check("rst_fields", {24'h0, opcode, dest_reg, src_reg}, 32'h00);
        check("rst_strobes", {27'h0, update_regs, update_flags, jump_taken, irq_ack, halted}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'd0);
        check("w_rst_pc", {20'h0, pc16}, 32'hFFF);

        @(negedge clk);
        reset = 1'b1;
        rst16 = 1'b1;
        req_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (state == 3'd0 && imem_req) req_cycles++;
            else break;
        end
        check("req_cycles", req_cycles, 32'd4);
        irq_en_set = 1'b1;
        @(negedge clk);
        irq_en_set = 1'b0;

        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        check("phase_a_pending", sb.size(), 32'd0);
        check("exe_len", exe_len_10, 32'd6);
        check("exe_early_strobe", {31'h0, exe_strobe_seen}, 32'd0);
        repeat (5) @(negedge clk);
        check("halt_hold", {23'h0, halted, pc}, {23'h1, 8'h30});

        // Second run: HALT at the reset vector, interrupt-enable initially clear.
        irq_mode = 0;
        mem[8'h00] = 8'hFF; wait_tab[8'h00] = 2;
        mem[8'h01] = 8'hFF;
        mem[8'h80] = 8'hFE;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #3;
        check("req_before_reset", {31'h0, imem_req}, 32'd1);
        reset = 1'b0;
        #1;
        check("req_async_drop", {31'h0, imem_req}, 32'd0);
        check("state_async_reset", {29'h0, state}, 32'd0);
        push(2, 0, 0, 0, 12'h000);   // HALT at reset vector
        push(1, 0, 0, 0, 12'h080);   // wake into IRQ
        push(0, 0, 0, 0, 12'h001);   // RETI to halt pc + 1
        push(2, 0, 0, 0, 12'h001);   // HALT again
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
        irq_mode = 2;
        repeat (10) @(negedge clk);
        check("halt_ie0_irq", {23'h0, halted, pc}, {23'h1, 8'h00});
        irq_en_set = 1'b1;
        @(negedge clk);
        irq_en_set = 1'b0;
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        check("phase_b_pending", sb.size(), 32'd0);
        check("w_pending", sb16.size(), 32'd0);
        check("w_halt_instr", {16'h0, instr16}, 32'hFFFF);
        check("w_halted", {31'h0, halted16}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
